fetch_unit: RTL and testbench

- Producer/initiator side of the instruction-queue fetch interface.
- Owns the PC and the 64-bit order counter, and issues one-word instruction reads to imem.
- Drives move_fetch / fetch_pc / fetch_pc_next / fetch_order into the queue, and forwards filtered imem responses (resp_fwd) into the queue's imem_resp input.
- On move_flush it redirects the PC and squashes in-flight responses, so stale words never enter the flushed queue.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/outstanding_tracker.sv | 75 +++++++
 rtl/fetch_unit.sv | 94 +++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   RESET_PC_DEFAULT : default PC after reset
//   OUTSTANDING_W    : width of the live/drop request counters
//   fetch_pkt_t      : push payload handed to the instruction queue
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
    localparam int unsigned OUTSTANDING_W    = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [63:0] order;
    } fetch_pkt_t;

endpackage

// File: rtl/outstanding_tracker.sv
// Tracks un-responded imem requests, split into live ones (response goes to
// the queue) and squashed ones (response is discarded after a flush).
// Responses return in request order, so squashed requests are always the
// oldest and are retired first.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : a request is issued this cycle
//   flush_i       : redirect; all live requests become squashed
//   resp_i        : imem response strobe
//   room_o        : another request may be issued this cycle
//   resp_fwd_o    : resp_i qualified for forwarding to the queue
module outstanding_tracker
    import fetch_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic flush_i,
    input  logic resp_i,
    output logic room_o,
    output logic resp_fwd_o
);

    localparam int unsigned SumW = OUTSTANDING_W + 1;

    logic [OUTSTANDING_W-1:0] live_q, live_d;
    logic [OUTSTANDING_W-1:0] drop_q, drop_d;
    logic [SumW-1:0]          inflight;
    logic                     drop_pending;

    assign drop_pending = (drop_q != '0);

    // Count after a same-cycle response retires its slot. An illegal response
    // with nothing outstanding wraps high and simply blocks the request.
    assign inflight = {1'b0, live_q} + {1'b0, drop_q} - SumW'(resp_i);
    assign room_o   = inflight < SumW'(MAX_OUTSTANDING);

    // The queue clears on a flush, so nothing is forwarded in that cycle.
    assign resp_fwd_o = resp_i && !flush_i && !drop_pending;

    always_comb begin
        live_d = live_q;
        drop_d = drop_q;
        if (flush_i) begin
            live_d = '0;
            drop_d = drop_q + live_q - OUTSTANDING_W'(resp_i);
        end else begin
            if (resp_i && drop_pending) begin
                drop_d = drop_q - OUTSTANDING_W'(1);
            end
            live_d = live_q + OUTSTANDING_W'(req_i)
                   - OUTSTANDING_W'(resp_i && !drop_pending);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q <= '0;
            drop_q <= '0;
        end else begin
            live_q <= live_d;
            drop_q <= drop_d;
        end
    end

    a_no_spurious_resp : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(resp_i && live_q == '0 && drop_q == '0))
        else $error("imem response with no outstanding request");

    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
        ({1'b0, live_q} + {1'b0, drop_q}) <= SumW'(MAX_OUTSTANDING))
        else $error("outstanding request count exceeds limit");

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: owns PC and order counter, issues one-word
// imem reads and pushes the matching slot into the instruction queue in the
// same cycle. A flush redirects the PC and squashes in-flight responses.
//   clk_i, rst_ni               : clock, async active-low reset
//   move_flush_i, flush_pc_i,
//   flush_order_i               : redirect request with new PC and order
//   instr_full_i                : queue head occupied, blocks fetch
//   move_fetch_o, fetch_pc_o,
//   fetch_pc_next_o,
//   fetch_order_o               : queue push strobe and payload
//   imem_addr_o, imem_rmask_o   : imem read request
//   imem_resp_i                 : imem response strobe (in order)
//   resp_fwd_o                  : non-squashed response for the queue
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        move_flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic [63:0] flush_order_i,
    input  logic        instr_full_i,
    output logic        move_fetch_o,
    output logic [31:0] fetch_pc_o,
    output logic [31:0] fetch_pc_next_o,
    output logic [63:0] fetch_order_o,
    output logic [31:0] imem_addr_o,
    output logic [3:0]  imem_rmask_o,
    input  logic        imem_resp_i,
    output logic        resp_fwd_o
);

    logic [31:0] pc_q, pc_d;
    logic [63:0] order_q, order_d;
    logic        room;
    logic        req;
    fetch_pkt_t  pkt;

    // Gating with rst_ni keeps the request strobe low while reset is held.
    assign req = rst_ni && !move_flush_i && !instr_full_i && room;

    outstanding_tracker #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_i      (req),
        .flush_i    (move_flush_i),
        .resp_i     (imem_resp_i),
        .room_o     (room),
        .resp_fwd_o (resp_fwd_o)
    );

    always_comb begin
        pkt.pc      = pc_q;
        pkt.pc_next = pc_q + 32'd4;
        pkt.order   = order_q;
    end

    always_comb begin
        move_fetch_o    = req;
        fetch_pc_o      = pkt.pc;
        fetch_pc_next_o = pkt.pc_next;
        fetch_order_o   = pkt.order;
        imem_addr_o     = pkt.pc;
        imem_rmask_o    = req ? 4'hf : 4'h0;
    end

    always_comb begin
        pc_d    = pc_q;
        order_d = order_q;
        if (move_flush_i) begin
            pc_d    = flush_pc_i;
            order_d = flush_order_i;
        end else if (req) begin
            pc_d    = pkt.pc_next;
            order_d = order_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q    <= RESET_PC;
            order_q <= '0;
        end else begin
            pc_q    <= pc_d;
            order_q <= order_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned MaxOut  = 2;
    localparam logic [31:0] RstPc   = 32'h1eceb000;
    localparam int          NumVec  = 23;
    localparam int          NumRand = 400;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        move_flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic [63:0] flush_order_i = '0;
    logic        instr_full_i = 1'b0;
    logic        imem_resp_i = 1'b0;
    logic        move_fetch_o;
    logic [31:0] fetch_pc_o;
    logic [31:0] fetch_pc_next_o;
    logic [63:0] fetch_order_o;
    logic [31:0] imem_addr_o;
    logic [3:0]  imem_rmask_o;
    logic        resp_fwd_o;

    fetch_unit #(
        .RESET_PC        (RstPc),
        .MAX_OUTSTANDING (MaxOut)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .move_flush_i    (move_flush_i),
        .flush_pc_i      (flush_pc_i),
        .flush_order_i   (flush_order_i),
        .instr_full_i    (instr_full_i),
        .move_fetch_o    (move_fetch_o),
        .fetch_pc_o      (fetch_pc_o),
        .fetch_pc_next_o (fetch_pc_next_o),
        .fetch_order_o   (fetch_order_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rmask_o    (imem_rmask_o),
        .imem_resp_i     (imem_resp_i),
        .resp_fwd_o      (resp_fwd_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Full output check given the expected request strobe, slot and forward.
    task automatic check_all(input string tag, input logic mv, input logic [31:0] pc,
                             input logic [63:0] ord, input logic fwd);
        check({tag, ".move_fetch"}, 64'(move_fetch_o), 64'(mv));
        check({tag, ".rmask"}, 64'(imem_rmask_o), mv ? 64'hf : 64'h0);
        check({tag, ".fetch_pc"}, 64'(fetch_pc_o), 64'(pc));
        check({tag, ".imem_addr"}, 64'(imem_addr_o), 64'(pc));
        check({tag, ".pc_next"}, 64'(fetch_pc_next_o), 64'(pc + 32'd4));
        check({tag, ".order"}, fetch_order_o, ord);
        check({tag, ".resp_fwd"}, 64'(resp_fwd_o), 64'(fwd));
    endtask

    typedef struct {
        logic        full;
        logic        flush;
        logic [31:0] fpc;
        logic [63:0] ford;
        logic        resp;
        logic        move;
        logic [31:0] pc;
        logic [63:0] ord;
        logic        fwd;
    } vec_t;

    vec_t vecs[NumVec];

    function automatic vec_t mk(input logic full, input logic flush, input logic [31:0] fpc,
                                input logic [63:0] ford, input logic resp, input logic move,
                                input logic [31:0] pc, input logic [63:0] ord,
                                input logic fwd);
        vec_t v;
        v.full = full; v.flush = flush; v.fpc = fpc; v.ford = ford; v.resp = resp;
        v.move = move; v.pc = pc; v.ord = ord; v.fwd = fwd;
        return v;
    endfunction

    // Reference model: one entry per outstanding request, in request order.
    bit          m_live[$];
    int unsigned m_ready[$];
    logic [31:0] m_pc;
    logic [63:0] m_ord;

    initial begin
        // Startup: fill, then issue, back-to-back, backpressure, two flush cases.
        vecs[0]  = mk(0, 0, 0, 0,   0, 1, 32'h1eceb000, 0,   0);
        vecs[1]  = mk(0, 0, 0, 0,   0, 1, 32'h1eceb004, 1,   0);
        vecs[2]  = mk(0, 0, 0, 0,   1, 1, 32'h1eceb008, 2,   1);
        vecs[3]  = mk(0, 0, 0, 0,   0, 0, 32'h1eceb00c, 3,   0);
        vecs[4]  = mk(0, 0, 0, 0,   1, 1, 32'h1eceb00c, 3,   1);
        vecs[5]  = mk(1, 0, 0, 0,   1, 0, 32'h1eceb010, 4,   1);
        vecs[6]  = mk(1, 0, 0, 0,   1, 0, 32'h1eceb010, 4,   1);
        vecs[7]  = mk(1, 0, 0, 0,   0, 0, 32'h1eceb010, 4,   0);
        vecs[8]  = mk(1, 0, 0, 0,   0, 0, 32'h1eceb010, 4,   0);
        vecs[9]  = mk(1, 0, 0, 0,   0, 0, 32'h1eceb010, 4,   0);
        vecs[10] = mk(0, 0, 0, 0,   0, 1, 32'h1eceb010, 4,   0);
        vecs[11] = mk(0, 0, 0, 0,   0, 1, 32'h1eceb014, 5,   0);
        vecs[12] = mk(0, 1, 32'h1eceb100, 37, 0, 0, 32'h1eceb018, 6, 0);
        vecs[13] = mk(0, 0, 0, 0,   1, 1, 32'h1eceb100, 37,  0);
        vecs[14] = mk(0, 0, 0, 0,   1, 1, 32'h1eceb104, 38,  0);
        vecs[15] = mk(0, 0, 0, 0,   1, 1, 32'h1eceb108, 39,  1);
        vecs[16] = mk(0, 1, 32'h1eceb200, 100, 1, 0, 32'h1eceb10c, 40, 0);
        vecs[17] = mk(0, 0, 0, 0,   0, 1, 32'h1eceb200, 100, 0);
        vecs[18] = mk(0, 0, 0, 0,   1, 1, 32'h1eceb204, 101, 0);
        vecs[19] = mk(0, 0, 0, 0,   1, 1, 32'h1eceb208, 102, 1);
        vecs[20] = mk(0, 0, 0, 0,   1, 1, 32'h1eceb20c, 103, 1);
        vecs[21] = mk(1, 0, 0, 0,   1, 0, 32'h1eceb210, 104, 1);
        vecs[22] = mk(1, 0, 0, 0,   1, 0, 32'h1eceb210, 104, 1);

        // Reset held for 3 cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_all("reset", 1'b0, RstPc, 64'd0, 1'b0);
        end
        rst_ni = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            instr_full_i  = vecs[i].full;
            move_flush_i  = vecs[i].flush;
            flush_pc_i    = vecs[i].fpc;
            flush_order_i = vecs[i].ford;
            imem_resp_i   = vecs[i].resp;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].move, vecs[i].pc, vecs[i].ord,
                      vecs[i].fwd);
            @(negedge clk_i);
        end

        // Async reset in the middle of a burst.
        instr_full_i = 1'b0; move_flush_i = 1'b0; imem_resp_i = 1'b0;
        #1;
        check_all("burst0", 1'b1, 32'h1eceb210, 64'd104, 1'b0);
        @(negedge clk_i);
        check_all("burst1", 1'b1, 32'h1eceb214, 64'd105, 1'b0);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check_all("async_rst", 1'b0, RstPc, 64'd0, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check_all("restart", 1'b1, RstPc, 64'd0, 1'b0);

        // Random phase, checked against the queue-based model.
        m_live.delete();
        m_ready.delete();
        m_live.push_back(1'b1);
        m_ready.push_back(2);
        m_pc  = RstPc + 32'd4;
        m_ord = 64'd1;
        @(negedge clk_i);
        for (int unsigned cyc = 1; cyc <= NumRand; cyc++) begin
            logic flush, full, resp, exp_req, exp_fwd;
            logic [31:0] fpc;
            logic [63:0] ford;
            flush = ($urandom_range(9) == 0);
            full  = ($urandom_range(3) == 0);
            fpc   = $urandom;
            ford  = {$urandom, $urandom};
            resp  = (m_ready.size() > 0) && (cyc >= m_ready[0]) && ($urandom_range(2) != 0);
            exp_req = !flush && !full && ((m_live.size() - int'(resp)) < int'(MaxOut));
            exp_fwd = resp && !flush && m_live[0];

            move_flush_i = flush; instr_full_i = full; flush_pc_i = fpc;
            flush_order_i = ford; imem_resp_i = resp;
            #1;
            check("rand.move_fetch", 64'(move_fetch_o), 64'(exp_req));
            check("rand.imem_addr", 64'(imem_addr_o), 64'(m_pc));
            check("rand.order", fetch_order_o, m_ord);
            check("rand.resp_fwd", 64'(resp_fwd_o), 64'(exp_fwd));

            if (resp) begin
                void'(m_live.pop_front());
                void'(m_ready.pop_front());
            end
            if (flush) begin
                foreach (m_live[k]) m_live[k] = 1'b0;
                m_pc  = fpc;
                m_ord = ford;
            end else if (exp_req) begin
                m_live.push_back(1'b1);
                m_ready.push_back(cyc + 1 + $urandom_range(2));
                m_pc  = m_pc + 32'd4;
                m_ord = m_ord + 64'd1;
            end
            @(negedge clk_i);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
